ncsi_tx_arbiter: RTL

- Sits directly downstream of the NCSI command/response buffer.
- Merges two AvST sources onto the single 32-bit transmit stream toward the RBT MAC:
  - the NCSI Response/AEN stream (b2a_nrtx_*);
  - the egress passthrough stream from the EPT buffer.
- Arbitrates only at packet boundaries, enforces a minimum inter-packet gap, and honours the eb4sr and rna qualifiers.
- Returns a one-cycle "sent" pulse to the response buffer.

---
 rtl/ncsi_tx_arb_pkg.sv | 24 ++
 rtl/ncsi_tx_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ncsi_tx_arb_pkg.sv
// Shared types and default sizing for the NCSI transmit arbiter.
package ncsi_tx_arb_pkg;

  localparam int unsigned DefaultIpgCycles   = 3;
  localparam int unsigned DefaultMaxPktWords = 384;

  typedef enum logic [2:0] {
    StIdle,
    StResp,
    StPt,
    StDrop,
    StIpg
  } arb_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  mod;
    logic        err;
    logic        vld;
  } avst_beat_t;

endpackage

// File: rtl/ncsi_tx_arbiter.sv
// Merges the NCSI response/AEN stream and the passthrough stream onto one AvST
// transmit stream, switching only at packet boundaries with an enforced gap.
module ncsi_tx_arbiter
  import ncsi_tx_arb_pkg::*;
#(
  parameter int unsigned IPG_CYCLES    = DefaultIpgCycles,
  parameter int unsigned MAX_PKT_WORDS = DefaultMaxPktWords
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        package_en,
  input  logic        ptnw_tx_en,
  input  logic [31:0] b2a_nrtx_data,
  input  logic        b2a_nrtx_sop,
  input  logic        b2a_nrtx_eop,
  input  logic [1:0]  b2a_nrtx_mod,
  input  logic        b2a_nrtx_err,
  input  logic        b2a_nrtx_rna,
  input  logic        b2a_nrtx_eb4sr,
  input  logic        b2a_nrtx_vld,
  output logic        b2a_nrtx_rdy,
  output logic        b2a_nrtx_sent,
  input  logic [31:0] ept_tx_data,
  input  logic        ept_tx_sop,
  input  logic        ept_tx_eop,
  input  logic        ept_tx_err,
  input  logic        ept_tx_vld,
  input  logic [1:0]  ept_tx_mod,
  output logic        ept_tx_rdy,
  output logic [31:0] arb_tx_data,
  output logic        arb_tx_sop,
  output logic        arb_tx_eop,
  output logic        arb_tx_err,
  output logic        arb_tx_vld,
  output logic [1:0]  arb_tx_mod,
  input  logic        arb_tx_rdy,
  output logic [15:0] arb_trunc_cnt
);

  localparam int unsigned BeatW = $clog2(MAX_PKT_WORDS + 1);
  localparam int unsigned IpgW  = $clog2(IPG_CYCLES + 2);

  arb_state_e       state_q;
  logic [BeatW-1:0] beat_cnt_q;
  logic [IpgW-1:0]  ipg_cnt_q;
  logic             eb4sr_done_q;
  logic             drop_resp_q;
  logic             drop_sent_q;
  logic             sent_q;
  logic [15:0]      trunc_cnt_q;

  avst_beat_t resp_beat, pt_beat, src;
  logic       resp_req, pt_req, fwd, fwd_resp, trunc_beat, accept, drop_end;

  assign resp_beat = '{data: b2a_nrtx_data, sop: b2a_nrtx_sop, eop: b2a_nrtx_eop,
                       mod: b2a_nrtx_mod, err: b2a_nrtx_err, vld: b2a_nrtx_vld};
  assign pt_beat   = '{data: ept_tx_data, sop: ept_tx_sop, eop: ept_tx_eop,
                       mod: ept_tx_mod, err: ept_tx_err, vld: ept_tx_vld};

  assign resp_req = b2a_nrtx_vld & b2a_nrtx_sop & package_en;
  assign pt_req   = ept_tx_vld & ept_tx_sop & ptnw_tx_en & package_en;

  assign fwd_resp   = !reset && (state_q == StResp);
  assign fwd        = fwd_resp || (!reset && (state_q == StPt));
  assign src        = fwd_resp ? resp_beat : pt_beat;
  // Last beat allowed before the packet is cut short and forced closed.
  assign trunc_beat = (32'(beat_cnt_q) == MAX_PKT_WORDS - 32'd1) && !src.eop;
  assign accept     = fwd && src.vld && arb_tx_rdy;
  assign drop_end   = drop_resp_q ? (b2a_nrtx_vld && b2a_nrtx_eop)
                                  : (ept_tx_vld && ept_tx_eop);

  assign arb_tx_vld    = fwd && src.vld;
  assign arb_tx_data   = fwd ? src.data : '0;
  assign arb_tx_sop    = fwd && src.sop;
  assign arb_tx_eop    = fwd && (src.eop || trunc_beat);
  assign arb_tx_err    = fwd && (src.err || trunc_beat);
  assign arb_tx_mod    = (fwd && !trunc_beat) ? src.mod : 2'd0;
  assign b2a_nrtx_sent = sent_q;
  assign arb_trunc_cnt = trunc_cnt_q;

  always_comb begin
    b2a_nrtx_rdy = 1'b0;
    ept_tx_rdy   = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          // Stray mid-packet beats with no sop are flushed while idle.
          b2a_nrtx_rdy = b2a_nrtx_vld && !b2a_nrtx_sop;
          ept_tx_rdy   = ept_tx_vld && !ept_tx_sop;
        end
        StResp: b2a_nrtx_rdy = arb_tx_rdy;
        StPt:   ept_tx_rdy   = arb_tx_rdy;
        StDrop: begin
          b2a_nrtx_rdy = drop_resp_q;
          ept_tx_rdy   = !drop_resp_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      beat_cnt_q   <= '0;
      ipg_cnt_q    <= '0;
      eb4sr_done_q <= 1'b0;
      drop_resp_q  <= 1'b0;
      drop_sent_q  <= 1'b0;
      sent_q       <= 1'b0;
      trunc_cnt_q  <= '0;
    end else begin
      sent_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          beat_cnt_q <= '0;
          if (resp_req && b2a_nrtx_rna) begin
            state_q     <= StDrop;
            drop_resp_q <= 1'b1;
            drop_sent_q <= 1'b1;
          end else if (resp_req && b2a_nrtx_eb4sr && pt_req && !eb4sr_done_q) begin
            state_q      <= StPt;
            eb4sr_done_q <= 1'b1;
          end else if (resp_req) begin
            state_q <= StResp;
          end else if (pt_req) begin
            state_q <= StPt;
          end
        end
        StResp, StPt: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + BeatW'(1);
            if (src.eop || trunc_beat) begin
              state_q   <= src.eop ? StIpg : StDrop;
              ipg_cnt_q <= '0;
              if (fwd_resp) begin
                sent_q       <= 1'b1;
                eb4sr_done_q <= 1'b0;
              end
            end
            if (trunc_beat) begin
              drop_resp_q <= fwd_resp;
              drop_sent_q <= 1'b0;
              if (trunc_cnt_q != 16'hFFFF) trunc_cnt_q <= trunc_cnt_q + 16'd1;
            end
          end
        end
        StDrop: begin
          if (drop_end) begin
            state_q   <= StIpg;
            ipg_cnt_q <= '0;
            if (drop_sent_q) begin
              sent_q       <= 1'b1;
              eb4sr_done_q <= 1'b0;
            end
          end
        end
        StIpg: begin
          if (32'(ipg_cnt_q) + 32'd1 >= IPG_CYCLES) state_q <= StIdle;
          else ipg_cnt_q <= ipg_cnt_q + IpgW'(1);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
